// File: rtl/lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter_if.sv
// Avalon debug-memory slave bus between a CPU-side master and the debug RAM arbiter.
// The master drives the request; the arbiter returns read data and the stall.
interface lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter_if;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        av_debugaccess;
    logic [31:0] av_readdata;
    logic        av_waitrequest;

    modport master (
        output av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
        input  av_readdata, av_waitrequest
    );

    modport slave (
        input  av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
        output av_readdata, av_waitrequest
    );
endinterface

// File: rtl/lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter.sv
// Shares the 256x32 OCI debug RAM between the JTAG debug host and the Avalon debug slave.
// JTAG pulses become queued RAM reads/writes with auto-incrementing address; Avalon stalls meanwhile.
module lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [37:0] i_jdo,
    input  logic        i_take_action_ocimem_a,
    input  logic        i_take_no_action_ocimem_a,
    input  logic        i_take_action_ocimem_b,
    lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter_if.slave av_if,
    output logic [7:0]  o_ram_addr,
    output logic [31:0] o_ram_wdata,
    output logic [3:0]  o_ram_be,
    output logic        o_ram_wr,
    output logic        o_ram_rd,
    input  logic [31:0] i_ram_rdata,
    output logic [31:0] o_MonDReg,
    output logic [7:0]  o_MonAReg,
    output logic        o_jtag_busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_AV_WR, S_AV_RD, S_AV_RWAIT, S_AV_DONE, S_JT_WR, S_JT_RD, S_JT_RWAIT
    } state_t;
    typedef enum logic {G_AV, G_JT} grant_t;

    state_t      r_state;
    grant_t      r_last_grant;
    logic        r_jt_rd_pend;
    logic        r_jt_wr_pend;
    logic [7:0]  r_ram_addr;
    logic [31:0] r_ram_wdata;
    logic [3:0]  r_ram_be;
    logic        r_ram_wr;
    logic        r_ram_rd;
    logic [31:0] r_av_readdata;
    logic [31:0] r_mon_dreg;
    logic [7:0]  r_mon_areg;

    logic w_jt_req;
    logic w_av_req;
    logic w_grant_jt;
    logic w_jdo_unused;

    assign w_jt_req     = r_jt_rd_pend | r_jt_wr_pend;
    assign w_av_req     = av_if.av_read | av_if.av_write;
    // On a tie the side that was not served last takes the RAM.
    assign w_grant_jt   = w_jt_req & (~w_av_req | (r_last_grant == G_AV));
    assign w_jdo_unused = ^{i_jdo[37:35], i_jdo[2:0]};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_last_grant  <= G_AV;
            r_jt_rd_pend  <= 1'b0;
            r_jt_wr_pend  <= 1'b0;
            r_ram_addr    <= 8'h00;
            r_ram_wdata   <= 32'h0;
            r_ram_be      <= 4'h0;
            r_ram_wr      <= 1'b0;
            r_ram_rd      <= 1'b0;
            r_av_readdata <= 32'h0;
            r_mon_dreg    <= 32'h0;
            r_mon_areg    <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ram_wr <= 1'b0;
                    r_ram_rd <= 1'b0;
                    if (w_grant_jt) begin
                        r_last_grant <= G_JT;
                        r_ram_addr   <= r_mon_areg;
                        if (r_jt_wr_pend) begin
                            r_state     <= S_JT_WR;
                            r_ram_wr    <= 1'b1;
                            r_ram_wdata <= r_mon_dreg;
                            r_ram_be    <= 4'hF;
                        end else begin
                            r_state  <= S_JT_RD;
                            r_ram_rd <= 1'b1;
                        end
                    end else if (w_av_req) begin
                        r_last_grant <= G_AV;
                        r_ram_addr   <= av_if.av_address;
                        if (av_if.av_read) begin
                            r_state  <= S_AV_RD;
                            r_ram_rd <= 1'b1;
                        end else begin
                            // Non-debug writes are acknowledged but never reach the RAM.
                            r_state     <= S_AV_WR;
                            r_ram_wr    <= av_if.av_debugaccess;
                            r_ram_wdata <= av_if.av_writedata;
                            r_ram_be    <= av_if.av_byteenable;
                        end
                    end
                end
                S_AV_WR: begin
                    r_ram_wr <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_AV_RD: begin
                    r_ram_rd <= 1'b0;
                    r_state  <= S_AV_RWAIT;
                end
                S_AV_RWAIT: begin
                    r_av_readdata <= i_ram_rdata;
                    r_state       <= S_AV_DONE;
                end
                S_AV_DONE: begin
                    r_state <= S_IDLE;
                end
                S_JT_WR: begin
                    r_ram_wr     <= 1'b0;
                    r_jt_wr_pend <= 1'b0;
                    r_mon_areg   <= r_mon_areg + 8'd1;
                    r_state      <= S_IDLE;
                end
                S_JT_RD: begin
                    r_ram_rd <= 1'b0;
                    r_state  <= S_JT_RWAIT;
                end
                S_JT_RWAIT: begin
                    r_mon_dreg   <= i_ram_rdata;
                    r_mon_areg   <= r_mon_areg + 8'd1;
                    r_jt_rd_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_ram_wr <= 1'b0;
                    r_ram_rd <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase

            // Host commands come last so a fresh pulse beats any same-cycle clear or update.
            if (i_take_action_ocimem_a) begin
                r_mon_areg   <= i_jdo[17:10];
                r_jt_rd_pend <= 1'b1;
            end
            if (i_take_no_action_ocimem_a) begin
                r_jt_rd_pend <= 1'b1;
            end
            if (i_take_action_ocimem_b) begin
                r_mon_dreg   <= i_jdo[34:3];
                r_jt_wr_pend <= 1'b1;
            end
        end
    end

    assign av_if.av_readdata    = r_av_readdata;
    assign av_if.av_waitrequest = w_av_req & ~((r_state == S_AV_WR) | (r_state == S_AV_DONE));

    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_ram_be    = r_ram_be;
    assign o_ram_wr    = r_ram_wr;
    assign o_ram_rd    = r_ram_rd;
    assign o_MonDReg   = r_mon_dreg;
    assign o_MonAReg   = r_mon_areg;
    assign o_jtag_busy = w_jt_req | (r_state == S_JT_WR) | (r_state == S_JT_RD) | (r_state == S_JT_RWAIT);
endmodule

// File: tb/tb_lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter.sv
// Bench for the debug RAM arbiter: directed timing sequences, a vector table and random
// transactions checked against a transaction-level model of the RAM and JTAG registers.
module tb_lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter;
    localparam int OP_JWR = 0, OP_JSET = 1, OP_JRD = 2, OP_AWR = 3, OP_ARD = 4, OP_ARW = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        tk_a = 1'b0, tk_na = 1'b0, tk_b = 1'b0;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic        ram_wr, ram_rd;
    logic [31:0] mon_d;
    logic [7:0]  mon_a;
    logic        busy;

    lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter_if av_if();

    lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter dut (
        .i_clk                     (clk),
        .i_reset_n                 (reset_n),
        .i_jdo                     (jdo),
        .i_take_action_ocimem_a    (tk_a),
        .i_take_no_action_ocimem_a (tk_na),
        .i_take_action_ocimem_b    (tk_b),
        .av_if                     (av_if),
        .o_ram_addr                (ram_addr),
        .o_ram_wdata               (ram_wdata),
        .o_ram_be                  (ram_be),
        .o_ram_wr                  (ram_wr),
        .o_ram_rd                  (ram_rd),
        .i_ram_rdata               (ram_rdata),
        .o_MonDReg                 (mon_d),
        .o_MonAReg                 (mon_a),
        .o_jtag_busy               (busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with a backdoor port used only while the arbiter is idle.
    logic [31:0] ram [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (ram_wr)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_rd) ram_rdata <= ram[ram_addr];
    end

    int n_both = 0;
    always @(negedge clk) if (ram_wr && ram_rd) n_both++;

    int n_cmp = 0, n_fail = 0;

    // Transaction-level model: memory image plus the two JTAG registers.
    logic [31:0] mm [256];
    logic [7:0]  ma = '0;
    logic [31:0] md = '0;

    typedef struct {
        int          op;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        bit          dbg;
        logic [31:0] exp_d;
        logic [7:0]  exp_a;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic [7:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; mm[a] = d;
        cyc();
        bd_we = 1'b0;
    endtask

    task automatic do_op(input int op, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit dbg,
                         output logic [31:0] got, output int lat);
        bit ok;
        ok = 1'b0; lat = 0; got = '0;
        cyc();
        if (op <= OP_JRD) begin
            jdo = '0;
            case (op)
                OP_JWR:  begin jdo[34:3] = d; tk_b = 1'b1; end
                OP_JSET: begin jdo[17:10] = a; tk_a = 1'b1; end
                default: tk_na = 1'b1;
            endcase
            cyc();
            tk_a = 1'b0; tk_na = 1'b0; tk_b = 1'b0;
            for (int k = 0; k < 20; k++) begin
                #1;
                if (!busy) begin ok = 1'b1; break; end
                cyc();
                lat++;
            end
            got = mon_d;
        end else begin
            av_if.av_address     = a;
            av_if.av_writedata   = d;
            av_if.av_byteenable  = be;
            av_if.av_debugaccess = dbg;
            av_if.av_read        = (op != OP_AWR);
            av_if.av_write       = (op != OP_ARD);
            for (int k = 0; k < 20; k++) begin
                #1;
                if (!av_if.av_waitrequest) begin ok = 1'b1; got = av_if.av_readdata; break; end
                cyc();
                lat++;
            end
            cyc();
            av_if.av_read = 1'b0; av_if.av_write = 1'b0;
        end
        chk("op_completes", 32'(ok), 32'd1);
    endtask

    task automatic mdl(input int op, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit dbg,
                       output logic [31:0] ed, output int el);
        ed = '0;
        case (op)
            OP_JWR:  begin mm[ma] = d; md = d; ma = ma + 8'd1; ed = md; el = 2; end
            OP_JSET: begin ma = a; md = mm[ma]; ma = ma + 8'd1; ed = md; el = 3; end
            OP_JRD:  begin md = mm[ma]; ma = ma + 8'd1; ed = md; el = 3; end
            OP_AWR:  begin
                if (dbg) for (int b = 0; b < 4; b++) if (be[b]) mm[a][8*b +: 8] = d[8*b +: 8];
                el = 1;
            end
            default: begin ed = mm[a]; el = 3; end
        endcase
    endtask

    task automatic run_op(input int op, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit dbg,
                          output logic [31:0] got, output int lat,
                          output logic [31:0] ed, output int el);
        do_op(op, a, d, be, dbg, got, lat);
        mdl(op, a, d, be, dbg, ed, el);
        $display("xact op=%0d addr=%h data=%h be=%h dbg=%0d got=%h lat=%0d mona=%h",
                 op, a, d, be, dbg, got, lat, mon_a);
    endtask

    task automatic do_reset();
        cyc();
        reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        ma = '0; md = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, ed;
        int lat, el;
        logic [31:0] wq [$];
        bit done;
        int ndiff;

        av_if.av_address = '0; av_if.av_read = 1'b0; av_if.av_write = 1'b0;
        av_if.av_writedata = '0; av_if.av_byteenable = '0; av_if.av_debugaccess = 1'b0;

        tbl[0]  = '{OP_AWR,  8'h30, 32'h11223344, 4'hF, 1'b1, 32'h0,        8'h00};
        tbl[1]  = '{OP_ARD,  8'h30, 32'h0,        4'hF, 1'b0, 32'h11223344, 8'h00};
        tbl[2]  = '{OP_AWR,  8'h30, 32'hAABBCCDD, 4'h5, 1'b1, 32'h0,        8'h00};
        tbl[3]  = '{OP_ARD,  8'h30, 32'h0,        4'hF, 1'b0, 32'h11BB33DD, 8'h00};
        tbl[4]  = '{OP_AWR,  8'h30, 32'h00000000, 4'hF, 1'b0, 32'h0,        8'h00};
        tbl[5]  = '{OP_ARD,  8'h30, 32'h0,        4'hF, 1'b0, 32'h11BB33DD, 8'h00};
        tbl[6]  = '{OP_JSET, 8'h30, 32'h0,        4'hF, 1'b0, 32'h11BB33DD, 8'h31};
        tbl[7]  = '{OP_JWR,  8'h00, 32'hCAFEF00D, 4'hF, 1'b0, 32'hCAFEF00D, 8'h32};
        tbl[8]  = '{OP_ARD,  8'h31, 32'h0,        4'hF, 1'b0, 32'hCAFEF00D, 8'h00};
        tbl[9]  = '{OP_AWR,  8'h32, 32'h5EED0001, 4'hF, 1'b1, 32'h0,        8'h00};
        tbl[10] = '{OP_JRD,  8'h00, 32'h0,        4'hF, 1'b0, 32'h5EED0001, 8'h33};
        tbl[11] = '{OP_ARW,  8'h31, 32'hFFFFFFFF, 4'hF, 1'b1, 32'hCAFEF00D, 8'h00};
        tbl[12] = '{OP_ARD,  8'h31, 32'h0,        4'hF, 1'b0, 32'hCAFEF00D, 8'h00};
        tbl[13] = '{OP_AWR,  8'hFF, 32'h0F0F0F0F, 4'hF, 1'b1, 32'h0,        8'h00};
        tbl[14] = '{OP_JSET, 8'hFF, 32'h0,        4'hF, 1'b0, 32'h0F0F0F0F, 8'h00};
        tbl[15] = '{OP_JWR,  8'h00, 32'h600DCAFE, 4'hF, 1'b0, 32'h600DCAFE, 8'h01};

        // Reset state; the stall follows the request even while in reset.
        repeat (3) cyc();
        av_if.av_read = 1'b1; #1;
        chk("rst_waitreq_req", 32'(av_if.av_waitrequest), 32'd1);
        av_if.av_read = 1'b0; #1;
        chk("rst_waitreq_idle", 32'(av_if.av_waitrequest), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_rd", 32'(ram_rd), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_ram_be", 32'(ram_be), 32'd0);
        chk("rst_readdata", av_if.av_readdata, 32'd0);
        chk("rst_mondreg", mon_d, 32'd0);
        chk("rst_monareg", 32'(mon_a), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        $display("xact reset released");

        // JTAG write at MonAReg 0x10: strobe two cycles after the pulse, then increment.
        set_mem(8'h0F, 32'h000000F0);
        do_op(OP_JSET, 8'h0F, 32'h0, 4'hF, 1'b0, got, lat);
        cyc();
        jdo = '0; jdo[34:3] = 32'hDEADBEEF; tk_b = 1'b1; #1;
        chk("jwr_n_ram_wr", 32'(ram_wr), 32'd0);
        cyc(); tk_b = 1'b0; #1;
        chk("jwr_n1_ram_wr", 32'(ram_wr), 32'd0);
        chk("jwr_n1_busy", 32'(busy), 32'd1);
        cyc(); #1;
        chk("jwr_n2_ram_wr", 32'(ram_wr), 32'd1);
        chk("jwr_n2_addr", 32'(ram_addr), 32'h10);
        chk("jwr_n2_wdata", ram_wdata, 32'hDEADBEEF);
        chk("jwr_n2_be", 32'(ram_be), 32'hF);
        cyc(); #1;
        chk("jwr_n3_ram_wr", 32'(ram_wr), 32'd0);
        chk("jwr_n3_monareg", 32'(mon_a), 32'h11);
        chk("jwr_n3_busy", 32'(busy), 32'd0);
        chk("jwr_ram_content", ram[8'h10], 32'hDEADBEEF);
        $display("xact jtag write DEADBEEF @10");

        // JTAG read at 0xFF: result at N+4 and address wraps to 0.
        set_mem(8'hFF, 32'h12345678);
        cyc();
        jdo = '0; jdo[17:10] = 8'hFF; tk_a = 1'b1; #1;
        cyc(); tk_a = 1'b0; #1;
        chk("jrd_n1_monareg", 32'(mon_a), 32'hFF);
        chk("jrd_n1_ram_rd", 32'(ram_rd), 32'd0);
        cyc(); #1;
        chk("jrd_n2_ram_rd", 32'(ram_rd), 32'd1);
        chk("jrd_n2_addr", 32'(ram_addr), 32'hFF);
        cyc(); #1;
        chk("jrd_n3_busy", 32'(busy), 32'd1);
        cyc(); #1;
        chk("jrd_n4_mondreg", mon_d, 32'h12345678);
        chk("jrd_n4_monareg_wrap", 32'(mon_a), 32'h00);
        chk("jrd_n4_busy", 32'(busy), 32'd0);
        $display("xact jtag read @FF");

        // Avalon read: stalled N..N+2, data at N+3.
        set_mem(8'h05, 32'hA5A5A5A5);
        cyc();
        av_if.av_address = 8'h05; av_if.av_read = 1'b1; #1;
        chk("ard_n_wait", 32'(av_if.av_waitrequest), 32'd1);
        cyc(); #1;
        chk("ard_n1_wait", 32'(av_if.av_waitrequest), 32'd1);
        chk("ard_n1_ram_rd", 32'(ram_rd), 32'd1);
        chk("ard_n1_addr", 32'(ram_addr), 32'h05);
        cyc(); #1;
        chk("ard_n2_wait", 32'(av_if.av_waitrequest), 32'd1);
        cyc(); #1;
        chk("ard_n3_wait", 32'(av_if.av_waitrequest), 32'd0);
        chk("ard_n3_data", av_if.av_readdata, 32'hA5A5A5A5);
        cyc(); av_if.av_read = 1'b0; #1;
        chk("ard_n4_ram_rd", 32'(ram_rd), 32'd0);
        $display("xact avalon read @05");

        // Avalon write without then with debugaccess.
        set_mem(8'h20, 32'h0BADF00D);
        for (int pass = 0; pass < 2; pass++) begin
            cyc();
            av_if.av_address = 8'h20; av_if.av_writedata = 32'h11112222;
            av_if.av_byteenable = 4'hF; av_if.av_debugaccess = (pass == 1);
            av_if.av_write = 1'b1; #1;
            chk("awr_n_wait", 32'(av_if.av_waitrequest), 32'd1);
            cyc(); #1;
            chk("awr_n1_wait", 32'(av_if.av_waitrequest), 32'd0);
            chk("awr_n1_ram_wr", 32'(ram_wr), 32'(pass));
            cyc(); av_if.av_write = 1'b0; #1;
            chk("awr_ram_content", ram[8'h20], (pass == 1) ? 32'h11112222 : 32'h0BADF00D);
            $display("xact avalon write @20 debugaccess=%0d", pass);
        end

        // From reset, a JTAG/Avalon tie goes to JTAG first, then Avalon.
        do_reset();
        cyc();
        jdo = '0; jdo[34:3] = 32'h00007777; tk_b = 1'b1; #1;
        cyc(); tk_b = 1'b0; av_if.av_address = 8'h05; av_if.av_read = 1'b1; #1;
        chk("tie_n1_wait", 32'(av_if.av_waitrequest), 32'd1);
        cyc(); #1;
        chk("tie_jtag_first_wr", 32'(ram_wr), 32'd1);
        chk("tie_jtag_first_rd", 32'(ram_rd), 32'd0);
        cyc(); #1;
        chk("tie_gap_wr", 32'(ram_wr), 32'd0);
        cyc(); #1;
        chk("tie_av_next_rd", 32'(ram_rd), 32'd1);
        chk("tie_av_next_addr", 32'(ram_addr), 32'h05);
        done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!av_if.av_waitrequest) begin done = 1'b1; break; end
            cyc(); #1;
        end
        chk("tie_av_done", 32'(done), 32'd1);
        chk("tie_av_data", av_if.av_readdata, 32'hA5A5A5A5);
        cyc(); av_if.av_read = 1'b0;
        $display("xact tie jtag-then-avalon");

        // Continuous contention: RAM writes must alternate JTAG, Avalon, JTAG, ...
        wq.delete();
        for (int c = 0; c < 14; c++) begin
            cyc();
            jdo = '0; jdo[34:3] = 32'hBBBB0000; tk_b = 1'b1;
            if (c >= 1) begin
                av_if.av_address = 8'h40; av_if.av_writedata = 32'hAAAA0000;
                av_if.av_byteenable = 4'hF; av_if.av_debugaccess = 1'b1; av_if.av_write = 1'b1;
            end
            #1;
            if (ram_wr) wq.push_back(ram_wdata);
        end
        cyc(); tk_b = 1'b0; av_if.av_write = 1'b0; #1;
        done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!busy) begin done = 1'b1; break; end
            cyc(); #1;
        end
        chk("rr_drain", 32'(done), 32'd1);
        chk("rr_grant_count", 32'(wq.size()), 32'd6);
        foreach (wq[k]) chk("rr_alternate", wq[k], (k % 2 == 0) ? 32'hBBBB0000 : 32'hAAAA0000);
        $display("xact round-robin grants=%0d", wq.size());

        // Asynchronous reset in AV_RWAIT aborts the read.
        cyc();
        av_if.av_address = 8'h05; av_if.av_read = 1'b1;
        cyc(); #1;
        chk("abort_n1_ram_rd", 32'(ram_rd), 32'd1);
        cyc();
        reset_n = 1'b0; #1;
        chk("abort_ram_rd", 32'(ram_rd), 32'd0);
        chk("abort_readdata", av_if.av_readdata, 32'd0);
        chk("abort_mondreg", mon_d, 32'd0);
        chk("abort_monareg", 32'(mon_a), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wait_idle", 32'(av_if.av_waitrequest), 32'd1);
        av_if.av_read = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        ma = '0; md = '0;
        $display("xact reset during avalon read");

        for (int i = 0; i < 256; i++) set_mem(8'(i), 32'(i) * 32'h9E3779B1);

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].dbg, got, lat, ed, el);
            chk("tbl_latency", 32'(lat), 32'(el));
            if (tbl[i].op >= OP_ARD) chk("tbl_readdata", got, tbl[i].exp_d);
            if (tbl[i].op <= OP_JRD) begin
                chk("tbl_mondreg", mon_d, tbl[i].exp_d);
                chk("tbl_monareg", 32'(mon_a), 32'(tbl[i].exp_a));
            end
        end

        for (int i = 0; i < 80; i++) begin
            int op;
            logic [7:0] a;
            logic [31:0] d;
            logic [3:0] be;
            bit dbg;
            op  = int'($urandom_range(0, 5));
            a   = 8'($urandom);
            d   = $urandom;
            be  = 4'($urandom_range(0, 15));
            dbg = ($urandom_range(0, 3) != 0);
            run_op(op, a, d, be, dbg, got, lat, ed, el);
            chk("rnd_latency", 32'(lat), 32'(el));
            if (op >= OP_ARD) chk("rnd_readdata", got, ed);
            if (op <= OP_JRD) begin
                chk("rnd_mondreg", mon_d, md);
                chk("rnd_monareg", 32'(mon_a), 32'(ma));
            end
        end

        ndiff = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== mm[i]) ndiff++;
        chk("mem_image_diffs", 32'(ndiff), 32'd0);
        chk("wr_rd_overlap_cycles", 32'(n_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter.md
# lt24_qsys_nios2_gen2_0_cpu_debug_mem_arbiter

Single-port arbiter and sequencer for the CPU debug RAM, the 256×32 synchronous OCI memory. It shares the RAM between two requesters. The first is the JTAG debug host, whose command strobes and `jdo` come from the debug-slave sysclk logic. The second is the CPU-side Avalon debug memory slave. It converts the one-cycle JTAG take-action pulses into RAM reads and writes with auto-incrementing address, returns results in `MonDReg`, and stalls Avalon masters via `av_waitrequest` while the JTAG side owns the RAM.

## Interface
- `clk` in 1: system clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `jdo` in 38: JTAG data-out register from the debug slave.
- `take_action_ocimem_a` in 1: pulse; load address, queue read.
- `take_no_action_ocimem_a` in 1: pulse; queue read at current address.
- `take_action_ocimem_b` in 1: pulse; load data, queue write.
- `av_address` in 8: Avalon word address.
- `av_read`, `av_write` in 1 each: Avalon requests, held until `av_waitrequest`=0.
- `av_writedata` in 32: Avalon write data.
- `av_byteenable` in 4: Avalon byte enables.
- `av_debugaccess` in 1: write qualifier for Avalon writes.
- `av_readdata` out 32: Avalon read data (registered).
- `av_waitrequest` out 1: Avalon stall.
- `ram_addr` out 8: RAM address (registered).
- `ram_wdata` out 32: RAM write data (registered).
- `ram_be` out 4: RAM byte enables (registered).
- `ram_wr`, `ram_rd` out 1 each: RAM strobes (registered).
- `ram_rdata` in 32: RAM read data, valid one cycle after `ram_rd`.
- `MonDReg` out 32: JTAG data register (write source / read result).
- `MonAReg` out 8: JTAG word address register.
- `jtag_busy` out 1: any JTAG request pending or in progress.

## Operation
- JTAG command decode, every cycle, independent of FSM state:
  - `take_action_ocimem_a`: `MonAReg`←`jdo[17:10]`; set `jt_rd_pend`.
  - `take_no_action_ocimem_a`: set `jt_rd_pend`.
  - `take_action_ocimem_b`: `MonDReg`←`jdo[34:3]`; set `jt_wr_pend`.
  - A pulse arriving while a pend flag is already set re-sets it (no queueing) and overwrites the register. This is a host protocol violation; the arbiter takes no other action.
- FSM states: IDLE, AV_WR, AV_RD, AV_RWAIT, AV_DONE, JT_WR, JT_RD, JT_RWAIT.
- In IDLE, candidates are JTAG (`jt_rd_pend|jt_wr_pend`) and Avalon (`av_read|av_write`).
  - Only one candidate: grant it.
  - Both candidates: round-robin via `last_grant`. The requester not granted last wins. `last_grant` resets to AV, so JTAG wins the first tie.
  - JTAG write and read both pending: the write is serviced first.
  - Avalon `av_read` and `av_write` both high: treated as a read.
- Avalon write: IDLE→AV_WR→IDLE.
  - In AV_WR: `ram_wr`=1 with registered address, data and byte enables.
  - If `av_debugaccess`=0, `ram_wr` is suppressed; the ack still occurs.
- Avalon read: IDLE→AV_RD (`ram_rd`=1)→AV_RWAIT (`av_readdata`←`ram_rdata` at end of cycle)→AV_DONE→IDLE.
- `av_waitrequest` = (`av_read`|`av_write`) & ~(state==AV_WR | state==AV_DONE).
- JTAG write: IDLE→JT_WR→IDLE.
  - In JT_WR: `ram_wr`=1, `ram_addr`=`MonAReg`, `ram_wdata`=`MonDReg`, `ram_be`=4'hF.
  - Clear `jt_wr_pend`; `MonAReg`+1 at end of JT_WR.
- JTAG read: IDLE→JT_RD (`ram_rd`=1, `ram_addr`=`MonAReg`)→JT_RWAIT→IDLE.
  - At end of JT_RWAIT: `MonDReg`←`ram_rdata`, `MonAReg`+1, clear `jt_rd_pend`.
- `MonAReg` increment is modulo 256 (8'hFF→8'h00).
- `jtag_busy` = `jt_rd_pend` | `jt_wr_pend` | state∈{JT_WR, JT_RD, JT_RWAIT}.
- A JTAG pulse in the same cycle the pend flag clears: the set wins and the flag stays 1.

## Timing
- Reset values: state IDLE, `last_grant`=AV, pend flags 0, `ram_wr`/`ram_rd`/`ram_addr`/`ram_wdata`/`ram_be`=0, `av_readdata`=0, `MonDReg`=0, `MonAReg`=0, `jtag_busy`=0. `av_waitrequest` equals (`av_read`|`av_write`) while in reset.
- Avalon write sampled in IDLE at cycle N: `ram_wr` and `av_waitrequest`=0 at N+1; next grant possible at N+2.
- Avalon read sampled at N: `ram_rd` at N+1, data captured end of N+2, `av_waitrequest`=0 with valid `av_readdata` at N+3, IDLE at N+4.
- JTAG write pulse at N (FSM idle): `ram_wr` at N+2, `MonAReg` incremented from N+3.
- JTAG read pulse at N (FSM idle): `ram_rd` at N+2, `MonDReg` valid and `jtag_busy`=0 at N+4.
- `ram_wr` and `ram_rd` are never both 1.
- Asynchronous reset mid-transaction aborts it: strobes drop immediately and no increment occurs.

## Test plan
- `take_action_ocimem_b` with `jdo[34:3]`=32'hDEADBEEF, `MonAReg`=8'h10 → `ram_wr` at addr 8'h10 data DEADBEEF be F; `MonAReg`=8'h11.
- `take_action_ocimem_a` with `jdo[17:10]`=8'hFF, RAM[FF]=32'h12345678 → `MonDReg`=12345678 at N+4; `MonAReg`=8'h00 (wrap).
- Avalon read addr 8'h05 (RAM=32'hA5A5A5A5) → `av_waitrequest` high N..N+2, low at N+3 with `av_readdata`=A5A5A5A5.
- Avalon write with `av_debugaccess`=0 → ack at N+1, `ram_wr` stays 0, RAM unchanged; repeat with `av_debugaccess`=1 → written.
- JTAG and Avalon requests raised in the same cycle from reset → JTAG granted first, Avalon next. Repeat continuously → grants alternate.
- Assert `reset_n`=0 during AV_RWAIT → `ram_rd`=0, state IDLE, `av_readdata`=0, `MonDReg`=0, `jtag_busy`=0.
